lbist_controller: RTL

- Top-level LBIST sequencer for one scan domain.
- On `start`, it seeds the pattern LFSR and clears the MISR, then runs N shift/capture pattern cycles and a final unload.
- It then compares the MISR signature against a golden value and reports done/pass.
- It drives the `inc` input of the shared pattern counter and keeps its own shift-bit and pattern counters for sequencing.

---
 rtl/lbist_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lbist_controller.sv
// LBIST sequencer for one scan domain: seed/clear, N shift+capture patterns, unload, signature compare.
// Optional debug observation ports are enabled by defining LBIST_CTRL_DBG_EN.
module lbist_controller #(
    parameter int BITS     = 8,
    parameter int SCAN_LEN = 16,
    parameter int SHW      = 5,
    parameter int SIG_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [BITS-1:0]  num_patterns,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             lfsr_seed_load,
    output logic             misr_clr,
    output logic             lfsr_en,
    output logic             misr_en,
    output logic             scan_en,
    output logic             pat_inc,
    output logic             busy,
    output logic             done,
    output logic             pass
`ifdef LBIST_CTRL_DBG_EN
    ,
    output logic [2:0]       dbg_state,
    output logic [BITS-1:0]  dbg_pat_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_UNLOAD  = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [SHW-1:0] LAST_SHIFT = SHW'(SCAN_LEN - 1);

    state_t           state, state_nxt;
    logic [SHW-1:0]   shift_cnt;
    logic [BITS-1:0]  pat_cnt;
    logic [BITS-1:0]  pat_nxt;
    logic [BITS-1:0]  n_lat;
    logic             pass_q;
    logic             last_shift;

    assign last_shift = (shift_cnt == LAST_SHIFT);
    assign pat_nxt    = pat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state_nxt = S_SEED;
                S_SEED:         state_nxt = (n_lat == '0) ? S_COMPARE : S_SHIFT;
                S_SHIFT:        if (last_shift) state_nxt = S_CAPTURE;
                S_CAPTURE:      state_nxt = (pat_nxt == n_lat) ? S_UNLOAD : S_SHIFT;
                S_UNLOAD:       if (last_shift) state_nxt = S_COMPARE;
                S_COMPARE:      state_nxt = S_DONE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    // shift_cnt is shared by SHIFT and UNLOAD; both leave it cleared on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt <= '0;
            pat_cnt   <= '0;
            n_lat     <= '0;
            pass_q    <= 1'b0;
        end else if (abort) begin
            shift_cnt <= '0;
            pat_cnt   <= '0;
            pass_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_lat  <= num_patterns;
                        pass_q <= 1'b0;
                    end
                end
                S_SEED: begin
                    shift_cnt <= '0;
                    pat_cnt   <= '0;
                end
                S_SHIFT, S_UNLOAD: shift_cnt <= last_shift ? '0 : shift_cnt + 1'b1;
                S_CAPTURE:         pat_cnt   <= pat_nxt;
                S_COMPARE:         pass_q    <= (misr_sig == golden_sig);
                default: ;
            endcase
        end
    end

    always_comb begin
        lfsr_seed_load = 1'b0;
        misr_clr       = 1'b0;
        lfsr_en        = 1'b0;
        misr_en        = 1'b0;
        scan_en        = 1'b0;
        pat_inc        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            S_SEED: begin
                lfsr_seed_load = 1'b1;
                misr_clr       = 1'b1;
                busy           = 1'b1;
            end
            S_SHIFT, S_UNLOAD: begin
                scan_en = 1'b1;
                lfsr_en = 1'b1;
                misr_en = 1'b1;
                busy    = 1'b1;
            end
            S_CAPTURE: begin
                // An aborted capture must not advance the shared external counter.
                pat_inc = ~abort;
                busy    = 1'b1;
            end
            S_COMPARE: busy = 1'b1;
            S_DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign pass = pass_q;

`ifdef LBIST_CTRL_DBG_EN
    assign dbg_state   = state;
    assign dbg_pat_cnt = pat_cnt;
`endif

endmodule
